swsc: RTL and testbench

//  Single-window separable 2-D convolution on a raster pixel stream. Applies one

---
 rtl/swsc.sv | 199 +++++++++++++++++++
 tb/tb_swsc.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swsc.sv
// swsc: streaming 7-tap separable 2-D convolution over a raster pixel stream.
// Vertical MAC on accept, horizontal MAC over a 7-deep column-sum shift reg.
module swsc #(
  parameter int                DATA_W     = 8,
  parameter int                KERNEL_H   = 7,
  parameter int                MAX_IMG_W  = 1024,
  parameter logic signed [4:0] WEIGHT_0   = 5'sd1,
  parameter logic signed [4:0] WEIGHT_1   = 5'sd3,
  parameter logic signed [4:0] WEIGHT_2   = 5'sd7,
  parameter logic signed [4:0] WEIGHT_3   = 5'sd10,
  parameter logic signed [4:0] WEIGHT_4   = 5'sd7,
  parameter logic signed [4:0] WEIGHT_5   = 5'sd3,
  parameter logic signed [4:0] WEIGHT_6   = 5'sd1,
  parameter int                NORM_SHIFT = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_eor,
  input  logic              i_eof,
  output logic              o_rdy,
  input  logic              i_rdy,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  localparam int NT = KERNEL_H;
  localparam int NB = NT - 1;
  localparam int AW = (MAX_IMG_W > 1) ? $clog2(MAX_IMG_W) : 1;
  localparam int CW = $clog2(MAX_IMG_W + 1);
  localparam int VW = DATA_W + 8;
  localparam int SW = VW + 8;

  localparam logic [NT-1:0][4:0] WT = {
    WEIGHT_6, WEIGHT_5, WEIGHT_4, WEIGHT_3,
    WEIGHT_2, WEIGHT_1, WEIGHT_0
  };

  localparam logic signed [SW-1:0] RND =
    SW'(1 << (NORM_SHIFT - 1));
  localparam logic signed [SW-1:0] MAXV =
    SW'((1 << DATA_W) - 1);

  function automatic logic signed [VW-1:0] wv(
    input logic [4:0] w
  );
    return {{(VW-5){w[4]}}, w};
  endfunction

  function automatic logic signed [SW-1:0] ws(
    input logic [4:0] w
  );
    return {{(SW-5){w[4]}}, w};
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] wid_q, wid_d;
  logic          wkn_q, wkn_d;
  logic [2:0]    row_q, row_d;

  logic          adv, acc, in_rng, emit;
  logic [AW-1:0] addr;

  logic [DATA_W-1:0] lb_q [NB][MAX_IMG_W];
  logic [DATA_W-1:0] win  [NT];

  logic signed [VW-1:0] v_d, v_q;
  logic signed [VW-1:0] hsr_q [NT];
  logic signed [SW-1:0] s_d, sr;
  logic [DATA_W-1:0]    res;

  logic              s1_vld_q, s1_emit_q, s2_vld_q;
  logic              o_vld_q;
  logic [DATA_W-1:0] o_data_q;

  // Whole pipeline moves in lockstep; it only halts when
  // the output register holds data the sink refuses.
  assign adv    = !o_vld_q || i_rdy;
  assign o_rdy  = !i_rst && adv;
  assign acc    = i_vld && o_rdy;
  assign in_rng = col_q < CW'(MAX_IMG_W);
  assign addr   = col_q[AW-1:0];

  assign emit = in_rng
             && (row_q == 3'd6)
             && (col_q >= CW'(6))
             && (!wkn_q || (col_q < wid_q));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    wid_d = wid_q;
    wkn_d = wkn_q;
    if (acc) begin
      if (i_eor) begin
        col_d = '0;
        if (row_q != 3'd6) row_d = row_q + 3'd1;
        if (!wkn_q) begin
          wkn_d = 1'b1;
          wid_d = in_rng ? col_q + CW'(1) : col_q;
        end
      end else if (in_rng) begin
        col_d = col_q + CW'(1);
      end
      if (i_eof) begin
        col_d = '0;
        row_d = '0;
        wkn_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
      wid_q <= '0;
      wkn_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      wid_q <= wid_d;
      wkn_q <= wkn_d;
    end
  end

  // Each column keeps its last six pixels oldest-first;
  // a new pixel pushes the column stack up by one row.
  always_ff @(posedge i_clk) begin
    if (acc && in_rng) begin
      for (int k = 0; k < NB - 1; k++) begin
        lb_q[k][addr] <= lb_q[k+1][addr];
      end
      lb_q[NB-1][addr] <= i_data;
    end
  end

  always_comb begin
    for (int k = 0; k < NB; k++) begin
      win[k] = lb_q[k][addr];
    end
    win[NB] = i_data;
  end

  always_comb begin
    v_d = '0;
    for (int k = 0; k < NT; k++) begin
      v_d = v_d + wv(WT[k])
          * $signed({{(VW-DATA_W){1'b0}}, win[k]});
    end
  end

  always_comb begin
    s_d = '0;
    for (int k = 0; k < NT; k++) begin
      s_d = s_d + ws(WT[k])
          * $signed({{(SW-VW){hsr_q[k][VW-1]}}, hsr_q[k]});
    end
    sr = (s_d + RND) >>> NORM_SHIFT;
    if (sr[SW-1]) begin
      res = '0;
    end else if (sr > MAXV) begin
      res = '1;
    end else begin
      res = sr[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (acc && adv) v_q <= v_d;
    if (adv && s1_vld_q) begin
      for (int k = 0; k < NT - 1; k++) begin
        hsr_q[k] <= hsr_q[k+1];
      end
      hsr_q[NT-1] <= v_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s1_emit_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      o_vld_q   <= 1'b0;
      o_data_q  <= '0;
    end else if (adv) begin
      s1_vld_q  <= acc && in_rng;
      s1_emit_q <= acc && emit;
      s2_vld_q  <= s1_vld_q && s1_emit_q;
      o_vld_q   <= s2_vld_q;
      if (s2_vld_q) o_data_q <= res;
    end
  end

  assign o_vld  = o_vld_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_swsc.sv
// tb_swsc: directed frames through two swsc instances (default and
// edge-enhancing weights) checked against a direct 2-D convolution model.
module tb_swsc;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [7:0] din;
  logic       eor;
  logic       eof;
  logic       rdy_in = 1'b1;
  logic       rdy_a, vld_a, rdy_b, vld_b;
  logic [7:0] dat_a, dat_b;

  always #5 clk = ~clk;

  swsc dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .i_vld (vld),
    .i_data(din),
    .i_eor (eor),
    .i_eof (eof),
    .o_rdy (rdy_a),
    .i_rdy (rdy_in),
    .o_vld (vld_a),
    .o_data(dat_a)
  );

  swsc #(
    .WEIGHT_0(-5'sd1),
    .WEIGHT_1(-5'sd2),
    .WEIGHT_2(-5'sd3),
    .WEIGHT_3(5'sd12),
    .WEIGHT_4(-5'sd3),
    .WEIGHT_5(-5'sd2),
    .WEIGHT_6(-5'sd1)
  ) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .i_vld (vld),
    .i_data(din),
    .i_eor (eor),
    .i_eof (eof),
    .o_rdy (rdy_b),
    .i_rdy (rdy_in),
    .o_vld (vld_b),
    .o_data(dat_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int wa [7] = '{1, 3, 7, 10, 7, 3, 1};
  int wb [7] = '{-1, -2, -3, 12, -3, -2, -1};
  int img [64][64];
  int qa [$];
  int qb [$];

  bit         rand_rdy = 1'b0;
  bit         gaps     = 1'b0;
  bit         stall_a  = 1'b0;
  logic [7:0] hold_a;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int y, input int x, input bit b);
    int s;
    s = 0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        if (b) s += wb[i] * wb[j] * img[y+i][x+j];
        else   s += wa[i] * wa[j] * img[y+i][x+j];
      end
    end
    s = (s + 512) >>> 10;
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    rdy_in = rand_rdy ? ($urandom_range(0, 9) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_a) begin
        chk("stall_vld", int'(vld_a), 1);
        chk("stall_data", int'(dat_a), int'(hold_a));
      end
      if (vld_a && rdy_in) qa.push_back(int'(dat_a));
      if (vld_b && rdy_in) qb.push_back(int'(dat_b));
      stall_a = vld_a && !rdy_in;
      hold_a  = dat_a;
    end else begin
      stall_a = 1'b0;
    end
  end

  task automatic send_px(input int d, input bit r, input bit f,
                         output bit ok);
    int t;
    ok = 1'b1;
    t  = 0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    vld = 1'b1;
    din = d[7:0];
    eor = r;
    eof = f;
    forever begin
      @(negedge clk);
      if (rdy_a) break;
      t++;
      if (t > 200) begin
        ok = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    eor = 1'b0;
    eof = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int npx);
    bit ok;
    int n;
    n = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n == npx) return;
        send_px(img[y][x], x == w - 1, (x == w - 1) && (y == h - 1), ok);
        n++;
        if (!ok) begin
          chk("accept_timeout", 0, 1);
          return;
        end
      end
    end
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input int w, input int n_exp);
    int ow;
    ow = w - 6;
    chk({tag, "_cnt_a"}, qa.size(), n_exp);
    chk({tag, "_cnt_b"}, qb.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < qa.size())
        chk({tag, "_pix_a"}, qa[i], model(i / ow, i % ow, 1'b0));
      if (i < qb.size())
        chk({tag, "_pix_b"}, qb[i], model(i / ow, i % ow, 1'b1));
    end
  endtask

  function automatic int at_a(input int i);
    return (i < qa.size()) ? qa[i] : -1;
  endfunction

  function automatic int at_b(input int i);
    return (i < qb.size()) ? qb[i] : -1;
  endfunction

  task automatic fill(input int kind);
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        case (kind)
          0:       img[y][x] = 0;
          1:       img[y][x] = 128;
          2:       img[y][x] = (x * 3 + y * 5) % 256;
          default: img[y][x] = $urandom_range(0, 255);
        endcase
      end
    end
  endtask

  task automatic qclear();
    qa.delete();
    qb.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    eor = 1'b0;
    eof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", int'(rdy_a), 0);
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_data", int'(dat_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", int'(rdy_a), 1);
    @(posedge clk);
    #1;

    // impulse: 255 at (10,10)
    fill(0);
    img[10][10] = 255;
    send_frame(20, 20, 400);
    drain();
    verify("t1", 20, 196);
    chk("t1_a_7_7", at_a(7 * 14 + 7), 25);
    chk("t1_a_7_6", at_a(7 * 14 + 6), 17);
    chk("t1_a_c00", at_a(0), 0);
    chk("t1_a_c0r", at_a(13), 0);
    chk("t1_a_cb0", at_a(182), 0);
    chk("t1_a_cbr", at_a(195), 0);
    chk("t2_b_7_7", at_b(7 * 14 + 7), 36);
    chk("t2_b_7_6", at_b(7 * 14 + 6), 0);
    qclear();

    // flat field
    fill(1);
    send_frame(16, 12, 192);
    drain();
    verify("t3", 16, 60);
    for (int i = 0; i < 60; i++) begin
      chk("t3_flat_a", at_a(i), 128);
      chk("t3_flat_b", at_b(i), 0);
    end
    qclear();

    // ramp with source gaps and sink stalls
    fill(2);
    gaps     = 1'b1;
    rand_rdy = 1'b1;
    send_frame(64, 48, 64 * 48);
    gaps = 1'b0;
    drain();
    verify("t4", 64, 2436);
    qclear();

    // reset in the middle of row 3
    fill(3);
    send_frame(20, 20, 3 * 20 + 9);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_rdy", int'(rdy_a), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_vld", int'(vld_a), 0);
    chk("t5_rst_data", int'(dat_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qclear();
    send_frame(20, 20, 400);
    drain();
    verify("t5", 20, 196);
    qclear();

    // narrow frame yields nothing; next frame is normal
    fill(3);
    send_frame(6, 10, 60);
    drain();
    chk("t6_narrow_a", qa.size(), 0);
    chk("t6_narrow_b", qb.size(), 0);
    qclear();
    fill(3);
    send_frame(10, 10, 100);
    drain();
    verify("t6", 10, 16);
    qclear();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
